// File: rtl/led_sched_pkg.sv
// -----------------------------------------------------------------------------
// led_sched_pkg
//
// Shared types and helpers for the LED mode scheduler:
//   - mode_e    : the four pattern modes, encoded as the mux select value
//   - state_e   : scheduler FSM states (RUN, HOLD, SWITCH)
//   - NUM_MODES : number of pattern modes, also the width of the enable vector
//   - width_min1: counter width helper that never returns zero
//   - next_mode : mode increment with natural 3 -> 0 wrap
// -----------------------------------------------------------------------------
package led_sched_pkg;

  localparam int unsigned NUM_MODES = 4;

  typedef enum logic [1:0] {
    MODE_BLINK = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SWITCH = 2'd2
  } state_e;

  // Width of a counter holding 0..value-1; at least one bit so that a
  // single-state counter still has a legal declaration.
  function automatic int unsigned width_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Four modes fill the 2-bit encoding, so the increment wraps 3 -> 0 by itself.
  function automatic mode_e next_mode(input mode_e mode);
    return mode_e'(mode + 2'd1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
//
// Prescaler that divides clk into a one-cycle pattern tick.
// The counter advances on every cycle with count_en high and wraps at
// TICK_DIV-1; the wrap cycle raises tick for the following cycle. clear
// forces the counter to zero and suppresses the tick, and takes priority
// over count_en.
//
// Parameters:
//   TICK_DIV  : clock cycles per tick, >= 2
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   count_en  in   advance the prescaler this cycle
//   clear     in   return the prescaler to zero (priority over count_en)
//   tick_next out  value tick takes at the next edge (lets the parent
//                  register outputs that must line up with tick)
//   tick      out  registered one-cycle tick
// -----------------------------------------------------------------------------
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic tick_next,
  output logic tick
);

  localparam int unsigned         CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q;
  logic             wrap;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wrap      = (count_q == LAST);
    tick_next = count_en && !clear && wrap;
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_next;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// -----------------------------------------------------------------------------
// led_mode_scheduler
//
// Selects which of the four LED pattern modules runs and feeds it a
// tick-qualified enable. Modes advance on a button press or, with auto_en,
// after DWELL_TICKS ticks in the current mode. Every mode change spends one
// SWITCH cycle pulsing mode_clr to the newly selected module; pause freezes
// the prescaler and dwell count in HOLD.
//
// Parameters:
//   TICK_DIV        : clock cycles per pattern tick, >= 2
//   DWELL_TICKS     : ticks per mode in auto rotation, >= 1
//   DEBOUNCE_CYCLES : consecutive high samples needed on btn_next
//                     (only with LED_SCHED_DEBOUNCE_EN)
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   btn_next in   advance-mode request (level)
//   auto_en  in   enable automatic rotation
//   pause    in   freeze tick and dwell count
//   mode_sel out  active mode index 0..3 (mux select for pattern outputs)
//   mode_en  out  one-hot enable to pattern module i, high only on tick cycles
//   mode_clr out  one-cycle clear for the newly selected pattern module
//   tick     out  one-cycle pattern tick
//
// Build option:
//   LED_SCHED_DEBOUNCE_EN : when defined, a press is accepted only after
//   btn_next has been high for DEBOUNCE_CYCLES consecutive cycles, and it
//   must go low again before the next press counts. When undefined, a plain
//   rising edge of btn_next is accepted.
// -----------------------------------------------------------------------------
module led_mode_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 25_000_000,
  parameter int unsigned DWELL_TICKS     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_next,
  input  logic                 auto_en,
  input  logic                 pause,
  output logic [1:0]           mode_sel,
  output logic [NUM_MODES-1:0] mode_en,
  output logic                 mode_clr,
  output logic                 tick
);

  localparam int unsigned          DWELL_W    = width_min1(DWELL_TICKS);
  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  state_e                 state_q, state_d;
  mode_e                  mode_q,  mode_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;
  logic [NUM_MODES-1:0]   en_q,    en_d;
  logic                   clr_q;

  logic btn_accept;
  logic dwell_expiry;
  logic advance;
  logic count_en;
  logic tick_next;

  // ---------------------------------------------------------------------------
  // Button acceptance
  // ---------------------------------------------------------------------------
`ifdef LED_SCHED_DEBOUNCE_EN
  localparam int unsigned        DB_W    = width_min1(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // db_cnt_q counts consecutive high samples before the accepting one;
  // db_done_q locks out further accepts until the button is seen low.
  logic [DB_W-1:0] db_cnt_q;
  logic            db_done_q;

  assign btn_accept = btn_next && !db_done_q && (db_cnt_q == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q  <= '0;
      db_done_q <= 1'b0;
    end else if (!btn_next) begin
      db_cnt_q  <= '0;
      db_done_q <= 1'b0;
    end else if (!db_done_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_cnt_q  <= '0;
        db_done_q <= 1'b1;
      end else begin
        db_cnt_q  <= db_cnt_q + 1'b1;
      end
    end
  end
`else
  logic btn_q;

  assign btn_accept = btn_next && !btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Advance request and prescaler control
  // ---------------------------------------------------------------------------
  // tick is only ever high in RUN, so it doubles as the RUN qualifier here.
  assign dwell_expiry = tick && auto_en && (state_q == RUN) && (dwell_q == DWELL_LAST);

  // A press arriving while SWITCH is in progress is dropped; a press and an
  // expiry in the same cycle still produce a single advance.
  assign advance = (btn_accept && (state_q != SWITCH)) || dwell_expiry;

  // Leaving SWITCH does not count, so the first tick after a mode change
  // lands TICK_DIV edges after the exit edge.
  assign count_en = !pause && (state_q != SWITCH);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .count_en  (count_en),
    .clear     (advance),
    .tick_next (tick_next),
    .tick      (tick)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    en_d    = '0;

    unique case (state_q)
      RUN: begin
        if (advance)    state_d = SWITCH;
        else if (pause) state_d = HOLD;
      end
      HOLD: begin
        if (advance)     state_d = SWITCH;
        else if (!pause) state_d = RUN;
      end
      SWITCH: begin
        state_d = pause ? HOLD : RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (advance) begin
      mode_d = next_mode(mode_q);
    end

    // A tick that coincides with an advance has already been delivered to
    // the old mode; the dwell count restarts for the new mode.
    if (advance || !auto_en) begin
      dwell_d = '0;
    end else if (tick) begin
      dwell_d = dwell_q + 1'b1;
    end

    // tick_next excludes advancing cycles, so mode_q is still the mode that
    // will be active when the tick is seen.
    if (tick_next) begin
      en_d[mode_q] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      mode_q  <= MODE_BLINK;
      dwell_q <= '0;
      en_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      en_q    <= en_d;
      clr_q   <= advance;
    end
  end

  assign mode_sel = mode_q;
  assign mode_en  = en_q;
  assign mode_clr = clr_q;

endmodule

// File: doc/led_mode_scheduler.md
# led_mode_scheduler

Sequencer for the four LED pattern modes of the combined LED design. It divides the system clock into a pattern tick and selects which pattern module is active, either manually from a button or automatically after a dwell time. It drives a one-hot, tick-qualified enable to each pattern module and a clear pulse when the mode changes. It sits between the board inputs and the pattern modules, whose outputs are muxed by `mode_sel`.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per pattern tick; must be ≥ 2.
- `DWELL_TICKS`, default 16: ticks per mode in auto rotation; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 250_000: stable-high cycles required on `btn_next`; used only with `LED_SCHED_DEBOUNCE_EN`.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `btn_next` in 1: advance-mode request, level input.
- `auto_en` in 1: enables automatic rotation after `DWELL_TICKS`.
- `pause` in 1: freezes the tick and the dwell count.
- `mode_sel` out 2: active mode index, 0..3.
- `mode_en` out 4: one-hot enable to pattern module i; high only on tick cycles.
- `mode_clr` out 1: one-cycle pulse that clears the newly selected pattern module.
- `tick` out 1: one-cycle pattern tick.

## Operation
- FSM states are RUN, HOLD and SWITCH. All outputs are registered.
- Reset values: state=RUN, `mode_sel`=0, prescaler=0, dwell=0, `tick`=0, `mode_en`=0, `mode_clr`=0, button edge register=0.
- RUN behaviour:
  - The prescaler increments each cycle.
  - At `TICK_DIV-1` the prescaler wraps to 0 and `tick` is set for the next cycle.
  - `mode_en[mode_sel]` follows `tick`; all other enable bits stay 0.
- HOLD is entered from RUN when `pause`=1. In HOLD the prescaler and dwell count hold their values and `tick` and `mode_en` are 0. When `pause`=0, the FSM returns to RUN and resumes from the held count.
- Dwell counter:
  - Counts ticks only while `auto_en`=1.
  - Cleared whenever `auto_en`=0.
  - Expiry means `tick`=1 and dwell=`DWELL_TICKS-1` while in RUN.
- Advance request: an accepted button edge in any state, or dwell expiry. The FSM enters SWITCH on the next edge and `mode_sel` increments on that same edge, wrapping 3→0.
- SWITCH lasts exactly one cycle:
  - `mode_clr`=1 and `mode_en`=0.
  - Prescaler and dwell are 0.
  - Next state is HOLD if `pause`=1, else RUN.
- Boundary cases:
  - A button edge and dwell expiry in the same cycle cause one advance only.
  - A button press while paused still advances; the FSM passes through SWITCH and then to HOLD.
  - A button edge during SWITCH is ignored.
  - A tick coincident with an advance is still delivered to the old mode.
- Asserting `reset` at any time returns everything to the reset values immediately. A pending advance is dropped.

## Timing
- Button latency: the rising edge of `btn_next` is sampled at edge k. At edge k, `mode_sel` updates and `mode_clr` goes high. At edge k+1 the FSM is in RUN with prescaler=0.
- After reset is released, the first `tick` appears after edge `TICK_DIV`.
- After SWITCH, the first `tick` appears after edge `TICK_DIV` counted from the edge that leaves SWITCH.
- `tick` and `mode_en` are never high in two consecutive cycles.
- Prescaler width is `$clog2(TICK_DIV)`. Dwell counter width is `$clog2(DWELL_TICKS)`, with a minimum of 1.

## Configuration
- `LED_SCHED_DEBOUNCE_EN` defined: a button edge is accepted once `btn_next` has been sampled high for `DEBOUNCE_CYCLES` consecutive cycles. After that, `btn_next` must be sampled low before the next press is accepted. The debounce counter resets on reset.
- Not defined: a button edge is accepted when `btn_next`=1 and its registered previous value is 0, with no filtering.

## Structure
- Package `led_sched_pkg` holds:
  - the mode enum: `MODE_BLINK`=0, `MODE_SHIFT`=1, `MODE_FILL`=2, `MODE_ALT`=3;
  - the FSM state enum: RUN, HOLD, SWITCH;
  - a `NUM_MODES`=4 constant.
- Sub-module `led_tick_gen` holds the prescaler. Its inputs are `count_en` and `clear`; its output is the registered `tick`.

## Test plan
- Reset release with `TICK_DIV`=4, `auto_en`=0 → `tick` and `mode_en[0]` are high after edges 4, 8, 12, …; `mode_sel` stays 0.
- `btn_next` held high for 10 cycles (no debounce) → exactly one advance; `mode_sel`=1 and `mode_clr` is high for one cycle.
- `auto_en`=1, `DWELL_TICKS`=3, `TICK_DIV`=4 → three ticks go to mode 0, then SWITCH with `mode_sel`=1. Four advances make `mode_sel` wrap 3→0.
- `pause`=1 for 20 cycles midway through a count → no `tick`; the tick resumes after the remaining count. Button press while paused → `mode_clr` pulses and the FSM returns to HOLD.
- Button edge in the same cycle as dwell expiry → `mode_sel` increments by exactly 1.
- `reset` asserted during SWITCH → `mode_sel`=0 and all outputs are 0 immediately. With `LED_SCHED_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=5, a 4-cycle pulse causes no advance.
